// File: rtl/ssd_msg_scroller_if.sv
// Control, write and display signals between a host and the message scroller.
interface ssd_msg_scroller_if #(
  parameter int unsigned CW = 4
);
  logic          tick;
  logic          hold;
  logic          clear;
  logic          start;
  logic          wr_en;
  logic [CW-1:0] wr_data;
  logic          wr_ready;
  logic          busy;
  logic [4:0]    msg_len;
  logic [CW-1:0] dig3;
  logic [CW-1:0] dig2;
  logic [CW-1:0] dig1;
  logic [CW-1:0] dig0;

  modport master (
    output tick, hold, clear, start, wr_en, wr_data,
    input  wr_ready, busy, msg_len, dig3, dig2, dig1, dig0
  );

  modport slave (
    input  tick, hold, clear, start, wr_en, wr_data,
    output wr_ready, busy, msg_len, dig3, dig2, dig1, dig0
  );
endinterface

// File: rtl/ssd_msg_scroller.sv
// Message buffer that presents a 4-character window scrolling through up to
// DEPTH stored character codes, one position per tick.
module ssd_msg_scroller #(
  parameter int unsigned   DEPTH = 16,
  parameter int unsigned   CW    = 4,
  parameter logic [CW-1:0] BLANK = CW'(4'hF)
) (
  input  logic                clk,
  input  logic                rst_n,
  ssd_msg_scroller_if.slave   bus
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NDIG   = 4;
  localparam logic [4:0]  DEPTH5 = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_e;

  state_e        state_q, state_d;
  logic [4:0]    count_q, count_d;
  logic [4:0]    head_q, head_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_ready_q, wr_ready_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] buf_q [DEPTH];
  logic [CW-1:0] buf_d [DEPTH];
  logic [CW-1:0] dig_q [NDIG];
  logic [CW-1:0] dig_d [NDIG];
  logic [4:0]    idx   [NDIG];
  logic [4:0]    nxt   [NDIG];
  logic          wr_acc;

  // Next-state: clear dominates, then write, then start, then tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    head_d   = head_q;
    wr_ptr_d = wr_ptr_q;
    buf_d    = buf_q;
    wr_acc   = 1'b0;
    if (bus.clear) begin
      state_d  = IDLE;
      count_d  = '0;
      head_d   = '0;
      wr_ptr_d = '0;
    end else begin
      wr_acc = bus.wr_en & wr_ready_q;
      if (wr_acc) begin
        buf_d[wr_ptr_q] = bus.wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
        count_d         = count_q + 5'd1;
      end
      unique case (state_q)
        IDLE:    if (wr_acc) state_d = LOAD;
        LOAD: begin
          if (bus.start) begin
            state_d = SCROLL;
            head_d  = '0;
          end
        end
        SCROLL: begin
          if (bus.tick && !bus.hold) begin
            head_d = ((head_q + 5'd1) == count_q) ? 5'd0 : head_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    wr_ready_d = (state_d != SCROLL) && (count_d < DEPTH5);
    busy_d     = (state_d == SCROLL);
  end

  // Window indices wrap at the message length by compare-and-reset; digits
  // are computed from next-cycle contents so they land with the event.
  always_comb begin
    idx[0] = head_d;
    nxt[0] = head_d;
    for (int k = 1; k < NDIG; k++) begin
      nxt[k] = idx[k-1] + 5'd1;
      idx[k] = (nxt[k] >= count_d) ? nxt[k] - count_d : nxt[k];
    end
    for (int k = 0; k < NDIG; k++) begin
      dig_d[k] = (count_d == 5'd0) ? BLANK : buf_d[AW'(idx[k])];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      head_q     <= '0;
      wr_ptr_q   <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      for (int k = 0; k < NDIG; k++) dig_q[k] <= BLANK;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      for (int k = 0; k < NDIG; k++) dig_q[k] <= dig_d[k];
    end
  end

  // Character storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) buf_q[k] <= buf_d[k];
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.busy     = busy_q;
  assign bus.msg_len  = count_q;
  assign bus.dig3     = dig_q[0];
  assign bus.dig2     = dig_q[1];
  assign bus.dig1     = dig_q[2];
  assign bus.dig0     = dig_q[3];

endmodule
